pe_result_writer: RTL and testbench



---
 rtl/winocnn_pkg.sv | 36 +++
 rtl/pe_result_writer_tile_sat_adder.sv | 31 +++
 rtl/pe_result_writer.sv | 123 ++++++++++++
 tb/tb_pe_result_writer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/winocnn_pkg.sv
// Shared constants, tile types and SRAM word pack/unpack helpers for the
// PE result write path.
package winocnn_pkg;

  localparam int DATA_W = 12;
  localparam int ACC_W  = 16;
  localparam int TILE   = 6;
  localparam int WORD_W = TILE * TILE * ACC_W;

  typedef logic [TILE-1:0][TILE-1:0][DATA_W-1:0] result_tile_t;
  typedef logic [TILE-1:0][TILE-1:0][ACC_W-1:0]  acc_tile_t;

  // Element (r,c) occupies bits [(r*TILE+c)*ACC_W +: ACC_W] of the SRAM word.
  function automatic logic [WORD_W-1:0] pack_acc_tile(input acc_tile_t t);
    logic [WORD_W-1:0] w;
    w = '0;
    for (int r = 0; r < TILE; r++) begin
      for (int c = 0; c < TILE; c++) begin
        w[(r*TILE+c)*ACC_W +: ACC_W] = t[r][c];
      end
    end
    return w;
  endfunction

  function automatic acc_tile_t unpack_acc_tile(input logic [WORD_W-1:0] w);
    acc_tile_t t;
    t = '0;
    for (int r = 0; r < TILE; r++) begin
      for (int c = 0; c < TILE; c++) begin
        t[r][c] = w[(r*TILE+c)*ACC_W +: ACC_W];
      end
    end
    return t;
  endfunction

endpackage

// File: rtl/pe_result_writer_tile_sat_adder.sv
// Combinational TILE x TILE adder: stored partial sum plus sign-extended PE
// element, saturated to the signed ACC_W range.
module tile_sat_adder
  import winocnn_pkg::*;
(
  input  acc_tile_t    base_i,
  input  result_tile_t tile_i,
  output acc_tile_t    sum_o
);

  logic [ACC_W:0] wide;

  // One extra bit of headroom; sign bits disagreeing means overflow.
  always_comb begin
    sum_o = '0;
    wide  = '0;
    for (int r = 0; r < TILE; r++) begin
      for (int c = 0; c < TILE; c++) begin
        wide = {base_i[r][c][ACC_W-1], base_i[r][c]}
             + {{(ACC_W+1-DATA_W){tile_i[r][c][DATA_W-1]}}, tile_i[r][c]};
        if (wide[ACC_W] != wide[ACC_W-1]) begin
          sum_o[r][c] = wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                    : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
          sum_o[r][c] = wide[ACC_W-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/pe_result_writer.sv
// Accumulating write path from one PE result stream into one output SRAM bank:
// S0 read issue, S1 forward + add, S2 write, S3 last-written shadow.
module pe_result_writer
  import winocnn_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int CNT_W  = 12
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start_i,
  input  logic [CNT_W-1:0]                      tiles_expected_i,
  input  logic [TILE-1:0][TILE-1:0][DATA_W-1:0] result_tile_i,
  input  logic [ADDR_W-1:0]                     result_address_i,
  input  logic                                  result_valid_i,
  input  logic                                  accumulate_i,
  output logic                                  mem_rd_en_o,
  output logic [ADDR_W-1:0]                     mem_rd_addr_o,
  input  logic [TILE*TILE*ACC_W-1:0]            mem_rd_data_i,
  output logic                                  mem_wr_en_o,
  output logic [ADDR_W-1:0]                     mem_wr_addr_o,
  output logic [TILE*TILE*ACC_W-1:0]            mem_wr_data_o,
  output logic                                  busy_o,
  output logic                                  done_o
);

  logic              s1_valid_q, s2_valid_q, s3_valid_q;
  result_tile_t      s1_tile_q;
  logic              s1_acc_q;
  logic [ADDR_W-1:0] s1_addr_q, s2_addr_q, s3_addr_q;
  acc_tile_t         s2_data_q, s3_data_q;
  acc_tile_t         base, s2_data_d;

  logic              armed_q, done_zero_q;
  logic [CNT_W-1:0]  cnt_q, exp_q, cnt_inc;

  assign mem_rd_en_o   = result_valid_i & ~reset;
  assign mem_rd_addr_o = result_valid_i ? result_address_i : {ADDR_W{1'b0}};

  // The SRAM returns pre-write data for a same-cycle read/write, so S2 and S3
  // must be forwarded; S2 is the youngest and wins.
  always_comb begin
    base = '0;
    if (!s1_acc_q) begin
      base = '0;
    end else if (s2_valid_q && (s2_addr_q == s1_addr_q)) begin
      base = s2_data_q;
    end else if (s3_valid_q && (s3_addr_q == s1_addr_q)) begin
      base = s3_data_q;
    end else begin
      base = unpack_acc_tile(mem_rd_data_i);
    end
  end

  tile_sat_adder u_adder (
    .base_i (base),
    .tile_i (s1_tile_q),
    .sum_o  (s2_data_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_tile_q  <= '0;
      s1_addr_q  <= '0;
      s1_acc_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_addr_q  <= '0;
      s2_data_q  <= '0;
      s3_valid_q <= 1'b0;
      s3_addr_q  <= '0;
      s3_data_q  <= '0;
    end else begin
      s1_valid_q <= result_valid_i;
      if (result_valid_i) begin
        s1_tile_q <= result_tile_i;
        s1_addr_q <= result_address_i;
        s1_acc_q  <= accumulate_i;
      end
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_addr_q <= s1_addr_q;
        s2_data_q <= s2_data_d;
      end
      s3_valid_q <= s2_valid_q;
      s3_addr_q  <= s2_addr_q;
      s3_data_q  <= s2_data_q;
    end
  end

  assign mem_wr_en_o   = s2_valid_q;
  assign mem_wr_addr_o = s2_addr_q;
  assign mem_wr_data_o = pack_acc_tile(s2_data_q);

  assign cnt_inc = cnt_q + CNT_W'(1);

  // A start coincident with a write takes priority; that write is not counted.
  always_ff @(posedge clk) begin
    if (reset) begin
      armed_q     <= 1'b0;
      cnt_q       <= '0;
      exp_q       <= '0;
      done_zero_q <= 1'b0;
    end else begin
      done_zero_q <= start_i && (tiles_expected_i == {CNT_W{1'b0}});
      if (start_i) begin
        cnt_q   <= '0;
        exp_q   <= tiles_expected_i;
        armed_q <= (tiles_expected_i != {CNT_W{1'b0}});
      end else if (armed_q && s2_valid_q) begin
        cnt_q <= cnt_inc;
        if (cnt_inc == exp_q) begin
          armed_q <= 1'b0;
        end
      end
    end
  end

  assign done_o = done_zero_q
                | (armed_q & s2_valid_q & ~start_i & (cnt_inc == exp_q));
  assign busy_o = s1_valid_q | s2_valid_q | armed_q;

endmodule

// File: tb/tb_pe_result_writer.sv
// Directed bench for pe_result_writer with a behavioural dual-port SRAM.
module tb_pe_result_writer;

  localparam int TILE = 6, DATA_W = 12, ACC_W = 16, ADDR_W = 12, CNT_W = 12;
  localparam int WW = TILE * TILE * ACC_W;
  localparam int TW = TILE * TILE * DATA_W;

  logic clk = 1'b0;
  logic reset, start_i, result_valid_i, accumulate_i;
  logic [CNT_W-1:0] tiles_expected_i;
  logic [TILE-1:0][TILE-1:0][DATA_W-1:0] result_tile_i;
  logic [ADDR_W-1:0] result_address_i;
  logic mem_rd_en_o, mem_wr_en_o, busy_o, done_o;
  logic [ADDR_W-1:0] mem_rd_addr_o, mem_wr_addr_o;
  logic [WW-1:0] mem_wr_data_o;
  bit   [WW-1:0] rd_data;

  bit [WW-1:0] mem [4096];
  logic pre_en;
  logic [ADDR_W-1:0] pre_addr;
  logic [WW-1:0] pre_word;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pe_result_writer #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .tiles_expected_i(tiles_expected_i),
    .result_tile_i(result_tile_i), .result_address_i(result_address_i),
    .result_valid_i(result_valid_i), .accumulate_i(accumulate_i),
    .mem_rd_en_o(mem_rd_en_o), .mem_rd_addr_o(mem_rd_addr_o), .mem_rd_data_i(rd_data),
    .mem_wr_en_o(mem_wr_en_o), .mem_wr_addr_o(mem_wr_addr_o), .mem_wr_data_o(mem_wr_data_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  // Dual-port SRAM: one-cycle read latency, same-cycle read returns old data.
  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_word;
    if (mem_wr_en_o) mem[mem_wr_addr_o] <= mem_wr_data_o;
    if (mem_rd_en_o) rd_data <= mem[mem_rd_addr_o];
  end

  // Element e = r*TILE+c holds base + k*e.
  function automatic logic [WW-1:0] make_word(input int base, input int k);
    logic [WW-1:0] w;
    w = '0;
    for (int e = 0; e < TILE*TILE; e++) w[e*ACC_W +: ACC_W] = 16'(base + k*e);
    return w;
  endfunction

  function automatic logic [TW-1:0] make_tile(input int base, input bit ramp);
    logic [TW-1:0] t;
    t = '0;
    for (int e = 0; e < TILE*TILE; e++) t[e*DATA_W +: DATA_W] = 12'(base + (ramp ? e : 0));
    return t;
  endfunction

  task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic drive(input bit v, input logic [ADDR_W-1:0] a, input bit acc,
                       input int val, input bit ramp);
    result_valid_i   = v;
    result_address_i = v ? a : 12'h000;
    accumulate_i     = acc;
    result_tile_i    = make_tile(val, ramp);
  endtask

  task automatic preload(input logic [ADDR_W-1:0] a, input int val);
    @(negedge clk);
    pre_en = 1'b1; pre_addr = a; pre_word = make_word(val, 0);
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  typedef struct {
    bit v; logic [ADDR_W-1:0] addr; bit acc; int val; bit ramp;
    bit ew; logic [ADDR_W-1:0] eaddr; int eval; int ek;
  } vec_t;

  function automatic vec_t mk(input bit v, input logic [ADDR_W-1:0] a, input bit acc,
                              input int val, input bit ramp, input bit ew,
                              input logic [ADDR_W-1:0] ea, input int ev, input int ek);
    vec_t x;
    x.v = v; x.addr = a; x.acc = acc; x.val = val; x.ramp = ramp;
    x.ew = ew; x.eaddr = ea; x.eval = ev; x.ek = ek;
    return x;
  endfunction

  vec_t vecs[24];
  bit s_tile[16];
  bit s_start[16];
  bit s_done[16];
  bit s_wr[16];
  logic [CNT_W-1:0] s_exp[16];

  initial begin
    reset = 1'b1; start_i = 1'b0; tiles_expected_i = '0;
    pre_en = 1'b0; pre_addr = '0; pre_word = '0;
    drive(1'b0, 12'h000, 1'b0, 0, 1'b0);

    // Rows: input in cycle i, expected write in cycle i (from row i-2).
    vecs[0]  = mk(1, 12'h010, 0,    5, 0, 0, 12'h000,      0, 0);
    vecs[1]  = mk(0, 12'h000, 0,    0, 0, 0, 12'h000,      0, 0);
    vecs[2]  = mk(0, 12'h000, 0,    0, 0, 1, 12'h010,      5, 0);
    vecs[3]  = mk(0, 12'h000, 0,    0, 0, 0, 12'h000,      0, 0);
    vecs[4]  = mk(1, 12'h020, 1,    3, 0, 0, 12'h000,      0, 0);
    vecs[5]  = mk(1, 12'h020, 1,    4, 0, 0, 12'h000,      0, 0);
    vecs[6]  = mk(0, 12'h000, 0,    0, 0, 1, 12'h020,    103, 0);
    vecs[7]  = mk(0, 12'h000, 0,    0, 0, 1, 12'h020,    107, 0);
    vecs[8]  = mk(1, 12'h030, 1,    3, 0, 0, 12'h000,      0, 0);
    vecs[9]  = mk(0, 12'h000, 0,    0, 0, 0, 12'h000,      0, 0);
    vecs[10] = mk(1, 12'h030, 1,    4, 0, 1, 12'h030,    103, 0);
    vecs[11] = mk(0, 12'h000, 0,    0, 0, 0, 12'h000,      0, 0);
    vecs[12] = mk(0, 12'h000, 0,    0, 0, 1, 12'h030,    107, 0);
    vecs[13] = mk(1, 12'h040, 1,  100, 0, 0, 12'h000,      0, 0);
    vecs[14] = mk(1, 12'h050, 1, -100, 0, 0, 12'h000,      0, 0);
    vecs[15] = mk(0, 12'h000, 0,    0, 0, 1, 12'h040,  32767, 0);
    vecs[16] = mk(0, 12'h000, 0,    0, 0, 1, 12'h050, -32768, 0);
    vecs[17] = mk(1, 12'h060, 0,   10, 1, 0, 12'h000,      0, 0);
    vecs[18] = mk(1, 12'h060, 1,    1, 1, 0, 12'h000,      0, 0);
    vecs[19] = mk(1, 12'h060, 1,    1, 1, 1, 12'h060,     10, 1);
    vecs[20] = mk(1, 12'h060, 0,    7, 0, 1, 12'h060,     11, 2);
    vecs[21] = mk(0, 12'h000, 0,    0, 0, 1, 12'h060,     12, 3);
    vecs[22] = mk(0, 12'h000, 0,    0, 0, 1, 12'h060,      7, 0);
    vecs[23] = mk(0, 12'h000, 0,    0, 0, 0, 12'h000,      0, 0);

    preload(12'h010, 100);
    preload(12'h020, 100);
    preload(12'h030, 100);
    preload(12'h040, 32760);
    preload(12'h050, -32760);
    preload(12'h060, 50);

    // Valid during reset must be ignored.
    @(negedge clk);
    drive(1'b1, 12'h010, 1'b0, 9, 1'b0);
    #1 check("rd_en in reset", WW'(mem_rd_en_o), WW'(0));
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 12'h000, 1'b0, 0, 1'b0);
    #1;
    check("reset wr_en", WW'(mem_wr_en_o), WW'(0));
    check("reset wr_addr", WW'(mem_wr_addr_o), WW'(0));
    check("reset wr_data", mem_wr_data_o, WW'(0));
    check("reset busy", WW'(busy_o), WW'(0));
    check("reset done", WW'(done_o), WW'(0));
    check("reset rd_en", WW'(mem_rd_en_o), WW'(0));
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      check($sformatf("post-reset wr_en %0d", i), WW'(mem_wr_en_o), WW'(0));
      check($sformatf("post-reset busy %0d", i), WW'(busy_o), WW'(0));
    end

    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      drive(vecs[i].v, vecs[i].addr, vecs[i].acc, vecs[i].val, vecs[i].ramp);
      #1;
      check($sformatf("row%0d rd_en", i), WW'(mem_rd_en_o), WW'(vecs[i].v));
      if (vecs[i].v) check($sformatf("row%0d rd_addr", i), WW'(mem_rd_addr_o), WW'(vecs[i].addr));
      check($sformatf("row%0d wr_en", i), WW'(mem_wr_en_o), WW'(vecs[i].ew));
      if (vecs[i].ew) begin
        check($sformatf("row%0d wr_addr", i), WW'(mem_wr_addr_o), WW'(vecs[i].eaddr));
        check($sformatf("row%0d wr_data", i), mem_wr_data_o, make_word(vecs[i].eval, vecs[i].ek));
      end
      check($sformatf("row%0d done unarmed", i), WW'(done_o), WW'(0));
    end

    // Count to 4: tiles in cycles 1,2,4,5 -> writes 3,4,6,7, done on 7.
    for (int i = 0; i < 16; i++) begin
      s_tile[i] = 0; s_start[i] = 0; s_done[i] = 0; s_wr[i] = 0; s_exp[i] = '0;
    end
    s_start[0] = 1; s_exp[0] = 12'd4;
    s_tile[1] = 1; s_tile[2] = 1; s_tile[4] = 1; s_tile[5] = 1;
    s_wr[3] = 1; s_wr[4] = 1; s_wr[6] = 1; s_wr[7] = 1;
    s_done[7] = 1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      start_i = s_start[i]; tiles_expected_i = s_exp[i];
      drive(s_tile[i], 12'(12'h100 + i), 1'b0, i, 1'b0);
      #1;
      check($sformatf("cnt4 c%0d done", i), WW'(done_o), WW'(s_done[i]));
      check($sformatf("cnt4 c%0d wr_en", i), WW'(mem_wr_en_o), WW'(s_wr[i]));
      check($sformatf("cnt4 c%0d busy", i), WW'(busy_o), WW'((i >= 1) && (i <= 7)));
    end

    // Zero expected tiles: done the cycle after start.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start_i = (i == 0); tiles_expected_i = 12'd0;
      drive(1'b0, 12'h000, 1'b0, 0, 1'b0);
      #1 check($sformatf("cnt0 c%0d done", i), WW'(done_o), WW'(i == 1));
    end

    // Restart at cycle 3 coincides with the first write, which is not counted;
    // writes in 4 and 5 reach the new expected count of 2.
    for (int i = 0; i < 16; i++) begin
      s_tile[i] = 0; s_start[i] = 0; s_done[i] = 0; s_exp[i] = '0;
    end
    s_start[0] = 1; s_exp[0] = 12'd2;
    s_start[3] = 1; s_exp[3] = 12'd2;
    s_tile[1] = 1; s_tile[2] = 1; s_tile[3] = 1;
    s_done[5] = 1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      start_i = s_start[i]; tiles_expected_i = s_exp[i];
      drive(s_tile[i], 12'(12'h200 + i), 1'b0, 1, 1'b0);
      #1 check($sformatf("restart c%0d done", i), WW'(done_o), WW'(s_done[i]));
    end
    start_i = 1'b0; tiles_expected_i = '0;

    // Reset the cycle after a valid tile discards it.
    @(negedge clk);
    drive(1'b1, 12'h300, 1'b0, 5, 1'b0);
    @(negedge clk);
    drive(1'b0, 12'h000, 1'b0, 0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      check($sformatf("midrst c%0d wr_en", i), WW'(mem_wr_en_o), WW'(0));
      check($sformatf("midrst c%0d wr_addr", i), WW'(mem_wr_addr_o), WW'(0));
      check($sformatf("midrst c%0d wr_data", i), mem_wr_data_o, WW'(0));
      check($sformatf("midrst c%0d busy", i), WW'(busy_o), WW'(0));
      check($sformatf("midrst c%0d done", i), WW'(done_o), WW'(0));
      check($sformatf("midrst c%0d rd_en", i), WW'(mem_rd_en_o), WW'(0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
